word_packer: RTL and testbench
==============================

# word_packer

Accumulates a stream of fixed-width input words into wide output words, with valid/ready backpressure on both sides, a group size selectable at run time, and early flush of partial groups via a last marker. It is the next generation of the team's serial word concatenator. It sits between narrow byte or word sources (UART, SPI, ADC front-ends) and wide consumers (FIFOs, DMA, memory writers) that can stall.

## Interface
- INPUT_WIDTH, 8, width of one input word.
- MAX_WORDS, 4, number of lanes in an output word; must be ≥1.
- ENDIAN, "little", lane order: "little" puts the first word in lane 0 (LSBs); "big" puts the first word in lane MAX_WORDS-1 (MSBs).
- OUTPUT_WIDTH, localparam, INPUT_WIDTH*MAX_WORDS.

Ports:
- clk_i  in  1  single clock; everything is on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- data_i  in  INPUT_WIDTH  input word.
- data_valid_i  in  1  data_i, last_i and num_words_i are valid.
- data_last_i  in  1  this word ends the group; flush even if the group is short.
- num_words_i  in  $clog2(MAX_WORDS+1)  group size; sampled with the first word of each group.
- data_ready_o  out  1  the block can accept a word this cycle.
- packed_data_o  out  OUTPUT_WIDTH  packed word.
- packed_keep_o  out  MAX_WORDS  one bit per lane, set when that lane holds a real word.
- packed_last_o  out  1  the group was closed by data_last_i.
- packed_valid_o  out  1  the packed outputs are valid.
- packed_ready_i  in  1  the consumer accepts the packed word.

## Operation
- An input word is accepted when data_valid_i && data_ready_o. An output word transfers when packed_valid_o && packed_ready_i.
- Group size N is latched when the first word of a group is accepted. num_words_i values of 0 or > MAX_WORDS are treated as MAX_WORDS. num_words_i is ignored for every other word of the group.
- Accepted word k of a group (k = 0..N-1) goes into lane k ("little") or lane MAX_WORDS-1-k ("big"). Lane j occupies bits [j*INPUT_WIDTH +: INPUT_WIDTH].
- A group completes when its N-th word is accepted, or when a word with data_last_i=1 is accepted, whichever comes first.
- Lanes that receive no word are zero, and their keep bits are 0. packed_last_o equals data_last_i of the completing word.
- Storage is one accumulator plus one output register, with a full flag on each.
- Completing word, output register free or draining this cycle: the merged accumulator plus the new word loads directly into the output register. The accumulator clears and stays ready.
- Completing word, output register held (valid and not ready): the merged word stays in the accumulator and acc_full is set. While acc_full=1, data_ready_o=0.
- When acc_full=1 and the output register frees (transfers, or is empty), the accumulator moves to the output register on that edge. acc_full clears, and data_ready_o returns to 1 in the next cycle.
- data_ready_o = !acc_full && !reset_i (combinational).
- While packed_valid_o=1 and packed_ready_i=0, the packed outputs hold stable.
- Sustained throughput is one input word per cycle for any N, including N=1, provided packed_ready_i stays high.

## Timing
- Reset (reset_i high at an edge):
  - packed_valid_o=0, packed_data_o=0, packed_keep_o=0, packed_last_o=0.
  - acc_full=0; lane index and word count go to 0.
  - Any partial group is discarded and produces no output.
  - data_ready_o=0 while reset_i is high and 1 in the first cycle after.
- Reset takes priority over any simultaneous input or output transfer.
- Latency: a completing word accepted at edge E makes packed_valid_o high from E onward (first visible cycle E+1), unless that word stalled into the accumulator.
- Simultaneous output transfer and completing input on the same edge: the new word loads into the output register with no bubble, and packed_valid_o stays high.
- Index arithmetic must not wrap for MAX_WORDS up to 64. The word counter is $clog2(MAX_WORDS+1) bits.

## Test plan
- Little-endian, MAX_WORDS=4, N=4, packed_ready_i=1: input 8'hf0, 8'h0f, 8'hba, 8'h11 on consecutive cycles -> one cycle after the 4th word, packed_data_o=32'h11ba0ff0, keep=4'b1111, last=0, valid high for exactly 1 cycle.
- ENDIAN="big", same stimulus -> packed_data_o=32'hf00fba11, keep=4'b1111.
- Little-endian, N=4: send 8'haa then 8'hbb with data_last_i=1 -> packed_data_o=32'h0000bbaa, keep=4'b0011, last=1. The next group starts in lane 0.
- Backpressure: packed_ready_i=0, stream 8 words with N=4 -> the first output holds stable. data_ready_o falls after the 8th word is accepted and no 9th word is taken. Raising packed_ready_i drains both outputs in order, with no loss or duplication.
- Runtime N: num_words_i=2 on the first group, then 0, then 1, with a continuous 1-word/cycle stream and ready=1 -> groups of 2, 4, 1 words with matching keep patterns and no stalls.
- Reset asserted after 2 of 4 words -> no output. After reset, a fresh 4-word group packs from lane 0 with correct data.

Source files
------------

// File: rtl/word_packer_if.sv
// Handshake bundle for word_packer: narrow input stream in, wide packed stream out.
interface word_packer_if #(
  parameter int INPUT_WIDTH = 8,
  parameter int MAX_WORDS   = 4
);
  localparam int OUTPUT_WIDTH = INPUT_WIDTH * MAX_WORDS;
  localparam int COUNT_WIDTH  = $clog2(MAX_WORDS + 1);

  logic [INPUT_WIDTH-1:0]  data_i;
  logic                    data_valid_i;
  logic                    data_last_i;
  logic [COUNT_WIDTH-1:0]  num_words_i;
  logic                    data_ready_o;
  logic [OUTPUT_WIDTH-1:0] packed_data_o;
  logic [MAX_WORDS-1:0]    packed_keep_o;
  logic                    packed_last_o;
  logic                    packed_valid_o;
  logic                    packed_ready_i;

  // Environment side: produces input words and consumes packed words.
  modport master (
    output data_i, data_valid_i, data_last_i, num_words_i, packed_ready_i,
    input  data_ready_o, packed_data_o, packed_keep_o, packed_last_o, packed_valid_o
  );

  // Packer side.
  modport slave (
    input  data_i, data_valid_i, data_last_i, num_words_i, packed_ready_i,
    output data_ready_o, packed_data_o, packed_keep_o, packed_last_o, packed_valid_o
  );
endinterface

// File: rtl/word_packer.sv
// word_packer: gathers groups of narrow input words into one wide output word.
// One accumulator collects the current group; a separate output register holds
// the finished word for the consumer. A finished group that cannot enter the
// output register parks in the accumulator (acc_full) and blocks new input.
module word_packer #(
  parameter int    INPUT_WIDTH = 8,
  parameter int    MAX_WORDS   = 4,
  parameter string ENDIAN      = "little"
) (
  input logic          clk_i,
  input logic          reset_i,
  word_packer_if.slave bus
);
  localparam int OUTPUT_WIDTH = INPUT_WIDTH * MAX_WORDS;
  localparam int CW           = $clog2(MAX_WORDS + 1);
  localparam bit BIG          = (ENDIAN == "big");
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  // Accumulator state
  logic [OUTPUT_WIDTH-1:0] acc_data_reg;
  logic [MAX_WORDS-1:0]    acc_keep_reg;
  logic                    acc_last_reg;
  logic                    acc_full_reg;
  logic [CW-1:0]           count_reg;   // words accepted so far in this group
  logic [CW-1:0]           size_reg;    // group size latched on the first word

  // Output register state
  logic [OUTPUT_WIDTH-1:0] out_data_reg;
  logic [MAX_WORDS-1:0]    out_keep_reg;
  logic                    out_last_reg;
  logic                    out_valid_reg;

  logic                    accept;
  logic                    first;
  logic                    complete;
  logic                    out_free;
  logic [CW-1:0]           size_eff;
  logic [CW:0]             count_inc;
  logic [MAX_WORDS-1:0]    lane_hit;
  logic [OUTPUT_WIDTH-1:0] merged_data;
  logic [MAX_WORDS-1:0]    merged_keep;

  assign accept    = bus.data_valid_i && bus.data_ready_o;
  assign first     = (count_reg == '0);
  assign out_free  = !out_valid_reg || bus.packed_ready_i;
  // One extra bit so count+1 never wraps even when the counter is full width.
  assign count_inc = {1'b0, count_reg} + (CW + 1)'(1);
  assign complete  = accept && ((count_inc == {1'b0, size_eff}) || bus.data_last_i);

  // Each lane knows statically which word position of a group lands in it,
  // so steering is a compare against the word counter rather than a shift.
  generate
    for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_lane
      localparam int K = BIG ? (MAX_WORDS - 1 - gi) : gi;
      assign lane_hit[gi] = (count_reg == CW'(K));
      assign merged_data[gi*INPUT_WIDTH +: INPUT_WIDTH] =
        lane_hit[gi] ? bus.data_i : acc_data_reg[gi*INPUT_WIDTH +: INPUT_WIDTH];
      assign merged_keep[gi] = lane_hit[gi] | acc_keep_reg[gi];
    end
  endgenerate

  // Effective group size: take num_words_i on the first word (0 or oversize means full), else the latched size.
  always_comb begin
    size_eff = size_reg;
    if (first) begin
      if ((bus.num_words_i == '0) || (bus.num_words_i > MAX_CNT)) begin
        size_eff = MAX_CNT;
      end else begin
        size_eff = bus.num_words_i;
      end
    end
  end

  // Accumulator and output register update, including the parked-group hand-off.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_data_reg  <= '0;
      acc_keep_reg  <= '0;
      acc_last_reg  <= 1'b0;
      acc_full_reg  <= 1'b0;
      count_reg     <= '0;
      size_reg      <= '0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (out_valid_reg && bus.packed_ready_i) begin
        out_valid_reg <= 1'b0;
      end
      if (acc_full_reg) begin
        // A parked group moves out as soon as the output register frees up.
        if (out_free) begin
          out_data_reg  <= acc_data_reg;
          out_keep_reg  <= acc_keep_reg;
          out_last_reg  <= acc_last_reg;
          out_valid_reg <= 1'b1;
          acc_data_reg  <= '0;
          acc_keep_reg  <= '0;
          acc_last_reg  <= 1'b0;
          acc_full_reg  <= 1'b0;
        end
      end else if (accept) begin
        if (complete) begin
          count_reg <= '0;
          if (out_free) begin
            out_data_reg  <= merged_data;
            out_keep_reg  <= merged_keep;
            out_last_reg  <= bus.data_last_i;
            out_valid_reg <= 1'b1;
            acc_data_reg  <= '0;
            acc_keep_reg  <= '0;
          end else begin
            acc_data_reg <= merged_data;
            acc_keep_reg <= merged_keep;
            acc_last_reg <= bus.data_last_i;
            acc_full_reg <= 1'b1;
          end
        end else begin
          acc_data_reg <= merged_data;
          acc_keep_reg <= merged_keep;
          count_reg    <= count_inc[CW-1:0];
          if (first) begin
            size_reg <= size_eff;
          end
        end
      end
    end
  end

  assign bus.data_ready_o   = !acc_full_reg && !reset_i;
  assign bus.packed_data_o  = out_data_reg;
  assign bus.packed_keep_o  = out_keep_reg;
  assign bus.packed_last_o  = out_last_reg;
  assign bus.packed_valid_o = out_valid_reg;
endmodule

// File: tb/tb_word_packer.sv
// Testbench for word_packer: a little-endian and a big-endian instance share
// identical stimulus; a group-list reference model predicts every packed word.
module tb_word_packer;
  localparam int IW = 8;
  localparam int MW = 4;
  localparam int CW = $clog2(MW + 1);
  localparam int OW = IW * MW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  word_packer_if #(.INPUT_WIDTH(IW), .MAX_WORDS(MW)) bus_l ();
  word_packer_if #(.INPUT_WIDTH(IW), .MAX_WORDS(MW)) bus_b ();

  word_packer #(.INPUT_WIDTH(IW), .MAX_WORDS(MW), .ENDIAN("little")) dut_l (
    .clk_i(clk), .reset_i(reset), .bus(bus_l.slave));
  word_packer #(.INPUT_WIDTH(IW), .MAX_WORDS(MW), .ENDIAN("big")) dut_b (
    .clk_i(clk), .reset_i(reset), .bus(bus_b.slave));

  int tests = 0;
  int fails = 0;
  int out_count = 0;

  typedef struct {
    logic [OW-1:0] dl;
    logic [OW-1:0] db;
    logic [MW-1:0] kl;
    logic [MW-1:0] kb;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] grp[$];
  int            grp_n = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_size(input int n);
    return (n == 0 || n > MW) ? MW : n;
  endfunction

  // Reference model: a group is just the list of accepted words; lanes follow from position.
  task automatic model_accept(input logic [IW-1:0] d, input logic last, input int num);
    exp_t e;
    if (grp.size() == 0) grp_n = eff_size(num);
    grp.push_back(d);
    if (grp.size() == grp_n || last) begin
      e.dl = '0; e.db = '0; e.kl = '0; e.kb = '0;
      foreach (grp[k]) begin
        e.dl[k*IW +: IW] = grp[k];
        e.kl[k] = 1'b1;
        e.db[(MW-1-k)*IW +: IW] = grp[k];
        e.kb[MW-1-k] = 1'b1;
      end
      e.last = last;
      exp_q.push_back(e);
      grp.delete();
    end
  endtask

  task automatic set_in(input logic [IW-1:0] d, input logic l, input int n, input logic v);
    bus_l.data_i = d; bus_l.data_last_i = l; bus_l.num_words_i = CW'(n); bus_l.data_valid_i = v;
    bus_b.data_i = d; bus_b.data_last_i = l; bus_b.num_words_i = CW'(n); bus_b.data_valid_i = v;
  endtask

  task automatic set_ready(input logic r);
    bus_l.packed_ready_i = r;
    bus_b.packed_ready_i = r;
  endtask

  // Present one word and hold it until accepted (bounded); returns one tick after the accepting edge.
  task automatic send_word(input logic [IW-1:0] d, input logic l, input int n, output int waited);
    waited = 0;
    set_in(d, l, n, 1'b1);
    forever begin
      @(negedge clk);
      if (bus_l.data_ready_o) break;
      waited++;
      if (waited > 50) begin
        check("send_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: feeds accepted words to the model and checks every output transfer and hold.
  initial begin : monitor
    logic          stall_prev;
    logic [OW-1:0] held_d;
    logic [MW-1:0] held_k;
    logic          held_l;
    exp_t          e;
    stall_prev = 1'b0;
    held_d = '0; held_k = '0; held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        grp.delete();
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", bus_l.packed_valid_o, 1);
          check("hold_data", bus_l.packed_data_o, held_d);
          check("hold_keep", bus_l.packed_keep_o, held_k);
          check("hold_last", bus_l.packed_last_o, held_l);
        end
        if (bus_l.packed_valid_o && bus_l.packed_ready_i) begin
          check("big_valid", bus_b.packed_valid_o, 1);
          check("out_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data_l", bus_l.packed_data_o, e.dl);
            check("out_keep_l", bus_l.packed_keep_o, e.kl);
            check("out_last_l", bus_l.packed_last_o, e.last);
            check("out_data_b", bus_b.packed_data_o, e.db);
            check("out_keep_b", bus_b.packed_keep_o, e.kb);
            check("out_last_b", bus_b.packed_last_o, e.last);
            $display("[TB] out #%0d data_l=%h keep_l=%b data_b=%h last=%0b",
                     out_count, bus_l.packed_data_o, bus_l.packed_keep_o,
                     bus_b.packed_data_o, bus_l.packed_last_o);
          end
          out_count++;
        end
        if (bus_l.data_valid_i && bus_l.data_ready_o) begin
          check("big_ready", bus_b.data_ready_o, 1);
          model_accept(bus_l.data_i, bus_l.data_last_i, int'(bus_l.num_words_i));
        end
        stall_prev = bus_l.packed_valid_o && !bus_l.packed_ready_i;
        held_d = bus_l.packed_data_o;
        held_k = bus_l.packed_keep_o;
        held_l = bus_l.packed_last_o;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Directed steps followed by a randomized phase.
  initial begin : stimulus
    logic [IW-1:0] w[8];
    int waited;
    int base;
    set_in('0, 1'b0, 0, 1'b0);
    set_ready(1'b1);
    reset = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus_l.data_ready_o, 0);
    check("rst_valid", bus_l.packed_valid_o, 0);
    check("rst_data", bus_l.packed_data_o, 0);
    check("rst_keep", bus_l.packed_keep_o, 0);
    check("rst_last", bus_l.packed_last_o, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", bus_l.data_ready_o, 1);

    // Full group of 4, both lane orders
    send_word(8'hf0, 1'b0, 4, waited);
    send_word(8'h0f, 1'b0, 4, waited);
    send_word(8'hba, 1'b0, 4, waited);
    send_word(8'h11, 1'b0, 4, waited);
    set_in('0, 1'b0, 0, 1'b0);
    check("t1_valid", bus_l.packed_valid_o, 1);
    check("t1_data_l", bus_l.packed_data_o, 32'h11ba0ff0);
    check("t1_data_b", bus_b.packed_data_o, 32'hf00fba11);
    check("t1_keep", bus_l.packed_keep_o, 4'b1111);
    check("t1_last", bus_l.packed_last_o, 0);
    @(posedge clk); #1;
    check("t1_one_cycle", bus_l.packed_valid_o, 0);

    // Early flush by last, then next group starts at lane 0
    send_word(8'haa, 1'b0, 4, waited);
    send_word(8'hbb, 1'b1, 4, waited);
    set_in('0, 1'b0, 0, 1'b0);
    check("t2_data_l", bus_l.packed_data_o, 32'h0000bbaa);
    check("t2_keep_l", bus_l.packed_keep_o, 4'b0011);
    check("t2_data_b", bus_b.packed_data_o, 32'haabb0000);
    check("t2_keep_b", bus_b.packed_keep_o, 4'b1100);
    check("t2_last", bus_l.packed_last_o, 1);
    send_word(8'hcc, 1'b0, 4, waited);
    send_word(8'hdd, 1'b0, 4, waited);
    send_word(8'hee, 1'b0, 4, waited);
    send_word(8'hff, 1'b0, 4, waited);
    set_in('0, 1'b0, 0, 1'b0);
    check("t2_next_data", bus_l.packed_data_o, 32'hffeeddcc);
    check("t2_next_last", bus_l.packed_last_o, 0);
    @(posedge clk); #1;

    // Backpressure: two groups stack up, ninth word refused, then both drain in order
    for (int i = 0; i < 8; i++) w[i] = IW'($urandom);
    set_ready(1'b0);
    for (int i = 0; i < 8; i++) send_word(w[i], 1'b0, 4, waited);
    @(negedge clk);
    check("bp_ready_low", bus_l.data_ready_o, 0);
    check("bp_hold_data", bus_l.packed_data_o, {w[3], w[2], w[1], w[0]});
    @(posedge clk); #1;
    set_in(8'h99, 1'b0, 4, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("bp_no_ninth", bus_l.data_ready_o, 0);
    end
    @(posedge clk); #1;
    set_in('0, 1'b0, 0, 1'b0);
    set_ready(1'b1);
    @(negedge clk);
    check("bp_first_out", bus_l.packed_data_o, {w[3], w[2], w[1], w[0]});
    @(posedge clk); #1;
    check("bp_second_valid", bus_l.packed_valid_o, 1);
    check("bp_second_out", bus_l.packed_data_o, {w[7], w[6], w[5], w[4]});
    check("bp_ready_back", bus_l.data_ready_o, 1);
    @(posedge clk); #1;
    check("bp_drained", bus_l.packed_valid_o, 0);

    // Runtime group size 2, 0 (=max), 1 with mid-group num values that must be ignored
    base = out_count;
    send_word(IW'($urandom), 1'b0, 2, waited); check("rn_stall0", waited, 0);
    send_word(IW'($urandom), 1'b0, 1, waited); check("rn_stall1", waited, 0);
    send_word(IW'($urandom), 1'b0, 0, waited); check("rn_stall2", waited, 0);
    send_word(IW'($urandom), 1'b0, 1, waited); check("rn_stall3", waited, 0);
    send_word(IW'($urandom), 1'b0, 2, waited); check("rn_stall4", waited, 0);
    send_word(IW'($urandom), 1'b0, 1, waited); check("rn_stall5", waited, 0);
    send_word(IW'($urandom), 1'b0, 1, waited); check("rn_stall6", waited, 0);
    set_in('0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rn_groups", out_count - base, 3);

    // Reset in the middle of a group discards it
    send_word(8'h12, 1'b0, 4, waited);
    send_word(8'h34, 1'b0, 4, waited);
    set_in('0, 1'b0, 0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_ready", bus_l.data_ready_o, 0);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_rst_no_out", bus_l.packed_valid_o, 0);
    end
    send_word(8'h01, 1'b0, 4, waited);
    send_word(8'h02, 1'b0, 4, waited);
    send_word(8'h03, 1'b0, 4, waited);
    send_word(8'h04, 1'b0, 4, waited);
    set_in('0, 1'b0, 0, 1'b0);
    check("post_rst_data", bus_l.packed_data_o, 32'h04030201);
    check("post_rst_keep", bus_l.packed_keep_o, 4'b1111);

    // Randomized traffic with random backpressure, checked by the monitor
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      set_in(IW'($urandom), ($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)),
             ($urandom_range(0, 3) != 0));
      set_ready($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    set_in('0, 1'b0, 0, 1'b0);
    set_ready(1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);
    check("rand_idle", bus_l.packed_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
